vram_arbiter: RTL and testbench
===============================

// Module: vram_arbiter
// PURPOSE
//  Shares the single-port 32 KB VRAM between the V9958 core (pixel/command fetch)
//  and an auxiliary requester (host-side block copy/fill or debug port).
//  VDP has absolute priority in its access window; aux uses every other cycle.
//  Sits between VDP PRAM* pins and ram32k; holds VDP read data so aux reads never disturb it.
// PARAMETERS
//  ADDR_W   15   VRAM address width (32 KB)
//  DATA_W   8    VRAM data width
//  STAT_W   16   width of saturating aux-blocked-cycle counter
// PORTS
//  clk          in   1       system clock; VRAM and VDP run on it
//  reset        in   1       synchronous, active-high
//  vdp_slot     in   1       VDP access window (VideoDLClk)
//  vdp_we_n     in   1       VDP write strobe, active low
//  vdp_oe_n     in   1       VDP read strobe, active low
//  vdp_adr      in   ADDR_W  VDP address (low bits of PRAMADR)
//  vdp_dbo      in   DATA_W  VDP write data
//  vdp_dbi      out  DATA_W  VDP read data, held until the next VDP read returns
//  aux_req      in   1       aux request, held until aux_ack
//  aux_wr       in   1       1 = write, 0 = read; qualified by aux_req
//  aux_adr      in   ADDR_W  aux address
//  aux_dbo      in   DATA_W  aux write data
//  aux_ack      out  1       comb.; 1 = aux access issued to RAM this cycle
//  aux_rdata    out  DATA_W  aux read data, registered
//  aux_rvalid   out  1       1-cycle pulse, aux_rdata valid
//  ram_we       out  1       to ram32k.we
//  ram_addr     out  ADDR_W  to ram32k.addr
//  ram_din      out  DATA_W  to ram32k.din
//  ram_dout     in   DATA_W  from ram32k.dout (1-cycle read latency)
//  stat_blocked out  STAT_W  saturating count of cycles aux_req was refused
// BEHAVIOUR
//  - vdp_acc = vdp_slot & (vdp_we_n ^ vdp_oe_n); both strobes low is no access.
//  - Grant (comb., same cycle): vdp_acc -> VDP owns RAM; else aux_req & ~reset ->
//    aux owns and aux_ack=1; else idle (ram_we=0, ram_addr=vdp_adr).
//  - ram_we = (VDP owns & ~vdp_we_n) | (aux owns & aux_wr); forced 0 while reset=1.
//  - ram_addr/ram_din come from the owner. Aux sees aux_ack every free cycle, so
//    back-to-back requests issue at one per cycle. Aux requester must not change
//    aux_* while aux_req=1 and aux_ack=0.
//  - rd_owner reg {NONE,VDP,AUX} records the read issued in cycle t
//    (writes record NONE); it selects the destination of ram_dout in t+1.
//  - vdp_dbi = (rd_owner==VDP) ? ram_dout : vdp_hold; vdp_hold <= ram_dout when
//    rd_owner==VDP. VDP read data is visible in t+1 and stable until the next VDP read.
//  - rd_owner==AUX in t+1 -> aux_rdata <= ram_dout and aux_rvalid=1 in t+2.
//    Aux read latency is 2 cycles from aux_ack; returns stay in issue order.
//  - aux write latency 0: data is in RAM at the clock edge ending the ack cycle.
//  - Same-address hazard: aux write at t then VDP read at t+1 returns new data
//    (RAM is sequential); no bypass is needed.
//  - stat_blocked increments when aux_req & ~aux_ack; saturates at all-ones;
//    never wraps.
//  - Reset (sync, any cycle incl. mid-read): rd_owner=NONE, vdp_hold=0,
//    aux_rdata=0, aux_rvalid=0, stat_blocked=0, aux_ack=0, ram_we=0.
//    A read in flight at reset produces no rvalid.
// TESTING
//  1 reset held 3 cycles with aux_req=1 -> aux_ack=0, ram_we=0, vdp_dbi=0, stat=0.
//  2 aux wr 0x1234<=0xA5 in free cycle, then aux rd 0x1234 -> ack each cycle;
//    rvalid 2 cycles after the read ack; aux_rdata=0xA5.
//  3 aux_req held across vdp_slot=1 with VDP read of 0x0010 (=0x3C) -> aux_ack=0
//    in slot, stat +1; vdp_dbi=0x3C next cycle and held through 5 following aux reads.
//  4 VDP write 0x7FFF<=0x5A in slot, aux read 0x7FFF in next cycle -> aux_rdata=0x5A.
//  5 slot with vdp_we_n=vdp_oe_n=0 and aux_req=1 -> treated as free; aux_ack=1,
//    ram_we follows aux_wr.
//  6 aux read acked, reset asserted next cycle -> no aux_rvalid; stat_blocked
//    forced to 0xFFFF by a long block stays at 0xFFFF.

Source files
------------

// File: rtl/vram_arbiter.sv
// ---------------------------------------------------------------------------
// vram_arbiter
//
// Purpose:
//   Shares the single-port 32 KB VRAM (ram32k) between the V9958 core and an
//   auxiliary requester (host block copy/fill or debug port). The VDP always
//   wins inside its access window; the aux port gets every other cycle.
//   Read data returning from the RAM is steered back to whichever side issued
//   the read one cycle earlier. The VDP read data is held locally, so aux
//   reads never disturb what the VDP sees on vdp_dbi.
//
// Ports:
//   clk          system clock shared by VDP and VRAM
//   reset        synchronous, active-high
//   vdp_slot     VDP access window (VideoDLClk)
//   vdp_we_n     VDP write strobe, active low
//   vdp_oe_n     VDP read strobe, active low
//   vdp_adr      VDP address
//   vdp_dbo      VDP write data
//   vdp_dbi      VDP read data, held until the next VDP read returns
//   aux_req      aux request, held by the requester until aux_ack
//   aux_wr       1 = write, 0 = read (qualified by aux_req)
//   aux_adr      aux address
//   aux_dbo      aux write data
//   aux_ack      combinational; aux access issued to the RAM this cycle
//   aux_rdata    aux read data, registered
//   aux_rvalid   one-cycle pulse marking aux_rdata valid
//   ram_we       write enable to ram32k
//   ram_addr     address to ram32k
//   ram_din      write data to ram32k
//   ram_dout     read data from ram32k (one-cycle read latency)
//   stat_blocked saturating count of cycles in which aux_req was refused
// ---------------------------------------------------------------------------
module vram_arbiter #(
  parameter int ADDR_W = 15,
  parameter int DATA_W = 8,
  parameter int STAT_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              vdp_slot,
  input  logic              vdp_we_n,
  input  logic              vdp_oe_n,
  input  logic [ADDR_W-1:0] vdp_adr,
  input  logic [DATA_W-1:0] vdp_dbo,
  output logic [DATA_W-1:0] vdp_dbi,
  input  logic              aux_req,
  input  logic              aux_wr,
  input  logic [ADDR_W-1:0] aux_adr,
  input  logic [DATA_W-1:0] aux_dbo,
  output logic              aux_ack,
  output logic [DATA_W-1:0] aux_rdata,
  output logic              aux_rvalid,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_din,
  input  logic [DATA_W-1:0] ram_dout,
  output logic [STAT_W-1:0] stat_blocked
);

  // Who issued the read whose data appears on ram_dout in the next cycle.
  typedef enum logic [1:0] {
    RD_NONE = 2'd0,
    RD_VDP  = 2'd1,
    RD_AUX  = 2'd2
  } rd_owner_t;

  rd_owner_t         rd_owner;
  rd_owner_t         rd_owner_nxt;
  logic [DATA_W-1:0] vdp_hold;
  logic [DATA_W-1:0] vdp_hold_nxt;
  logic [DATA_W-1:0] aux_rdata_nxt;
  logic              aux_rvalid_nxt;
  logic [STAT_W-1:0] stat_nxt;

  logic              vdp_acc;
  logic              aux_grant;

  // A VDP access needs exactly one strobe low inside the slot. Both strobes
  // low is a malformed cycle and is treated as if the VDP were idle, which
  // hands the cycle to the aux port.
  always_comb begin
    vdp_acc   = vdp_slot & (vdp_we_n ^ vdp_oe_n);
    aux_grant = ~vdp_acc & aux_req & ~reset;
  end

  // RAM-side mux. The VDP address is parked on the bus when nobody owns the
  // RAM so the idle bus looks like a VDP read with no strobe. Write enable is
  // masked by reset so a stray request can never corrupt VRAM while the
  // system is held.
  always_comb begin
    aux_ack  = aux_grant;
    ram_addr = vdp_adr;
    ram_din  = vdp_dbo;
    ram_we   = 1'b0;
    if (vdp_acc) begin
      ram_addr = vdp_adr;
      ram_din  = vdp_dbo;
      ram_we   = ~vdp_we_n & ~reset;
    end else if (aux_grant) begin
      ram_addr = aux_adr;
      ram_din  = aux_dbo;
      ram_we   = aux_wr;
    end
  end

  // VDP read data: passed straight through in the cycle its read returns,
  // otherwise the last returned VDP byte, so the core sees stable data no
  // matter how many aux reads are squeezed in between.
  always_comb begin
    vdp_dbi = (rd_owner == RD_VDP) ? ram_dout : vdp_hold;
  end

  // Next-state logic for the read-return tracker, the data holding
  // registers and the blocked-cycle statistic. Writes record RD_NONE so a
  // write never steers a stale ram_dout anywhere. The statistic stops at
  // all-ones rather than wrapping so a long stall is never reported as short.
  always_comb begin
    rd_owner_nxt   = RD_NONE;
    vdp_hold_nxt   = vdp_hold;
    aux_rdata_nxt  = aux_rdata;
    aux_rvalid_nxt = 1'b0;
    stat_nxt       = stat_blocked;

    if (vdp_acc && !vdp_oe_n) begin
      rd_owner_nxt = RD_VDP;
    end else if (aux_grant && !aux_wr) begin
      rd_owner_nxt = RD_AUX;
    end

    if (rd_owner == RD_VDP) begin
      vdp_hold_nxt = ram_dout;
    end

    if (rd_owner == RD_AUX) begin
      aux_rdata_nxt  = ram_dout;
      aux_rvalid_nxt = 1'b1;
    end

    if (aux_req && !aux_ack && (stat_blocked != {STAT_W{1'b1}})) begin
      stat_nxt = stat_blocked + STAT_W'(1);
    end
  end

  // State registers. Reset clears the read tracker too, so a read that was
  // in flight when reset arrived never produces an aux_rvalid afterwards.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_owner     <= RD_NONE;
      vdp_hold     <= '0;
      aux_rdata    <= '0;
      aux_rvalid   <= 1'b0;
      stat_blocked <= '0;
    end else begin
      rd_owner     <= rd_owner_nxt;
      vdp_hold     <= vdp_hold_nxt;
      aux_rdata    <= aux_rdata_nxt;
      aux_rvalid   <= aux_rvalid_nxt;
      stat_blocked <= stat_nxt;
    end
  end

endmodule

// File: tb/tb_vram_arbiter.sv
// ---------------------------------------------------------------------------
// tb_vram_arbiter
//
// Purpose:
//   Self-checking bench for vram_arbiter. A behavioural ram32k (synchronous
//   write, one-cycle read latency) sits on the RAM side. Grant decoding is
//   exercised from a vector table; the multi-cycle behaviour (read latency,
//   VDP data hold, reset mid-read, counter saturation) uses hand sequences.
// ---------------------------------------------------------------------------
module tb_vram_arbiter;

  logic        clk;
  logic        reset;
  logic        vdp_slot;
  logic        vdp_we_n;
  logic        vdp_oe_n;
  logic [14:0] vdp_adr;
  logic [7:0]  vdp_dbo;
  logic [7:0]  vdp_dbi;
  logic        aux_req;
  logic        aux_wr;
  logic [14:0] aux_adr;
  logic [7:0]  aux_dbo;
  logic        aux_ack;
  logic [7:0]  aux_rdata;
  logic        aux_rvalid;
  logic        ram_we;
  logic [14:0] ram_addr;
  logic [7:0]  ram_din;
  logic [7:0]  ram_dout;
  logic [15:0] stat_blocked;

  // One cycle of stimulus together with the combinational response expected
  // in that same cycle.
  typedef struct {
    logic        rst;
    logic        slot;
    logic        we_n;
    logic        oe_n;
    logic [14:0] vadr;
    logic [7:0]  vdbo;
    logic        req;
    logic        wr;
    logic [14:0] aadr;
    logic [7:0]  adbo;
    logic        exp_ack;
    logic        exp_we;
    logic [14:0] exp_addr;
  } vec_t;

  int          pass_cnt;
  int          check_cnt;
  logic [15:0] exp_stat;
  vec_t        prev;
  vec_t        tbl [8];
  logic [7:0]  mem [0:32767];

  vram_arbiter #(
    .ADDR_W(15),
    .DATA_W(8),
    .STAT_W(16)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .vdp_slot    (vdp_slot),
    .vdp_we_n    (vdp_we_n),
    .vdp_oe_n    (vdp_oe_n),
    .vdp_adr     (vdp_adr),
    .vdp_dbo     (vdp_dbo),
    .vdp_dbi     (vdp_dbi),
    .aux_req     (aux_req),
    .aux_wr      (aux_wr),
    .aux_adr     (aux_adr),
    .aux_dbo     (aux_dbo),
    .aux_ack     (aux_ack),
    .aux_rdata   (aux_rdata),
    .aux_rvalid  (aux_rvalid),
    .ram_we      (ram_we),
    .ram_addr    (ram_addr),
    .ram_din     (ram_din),
    .ram_dout    (ram_dout),
    .stat_blocked(stat_blocked)
  );

  // Free-running 10 ns clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural ram32k: write at the edge, registered read of the old
  // contents.
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_din;
    ram_dout <= mem[ram_addr];
  end

  function automatic vec_t mkIdle();
    vec_t v;
    v = '{1'b0, 1'b0, 1'b1, 1'b1, 15'h0000, 8'h00,
          1'b0, 1'b0, 15'h0000, 8'h00, 1'b0, 1'b0, 15'h0000};
    return v;
  endfunction

  function automatic vec_t auxVec(input logic wr, input logic [14:0] a,
                                  input logic [7:0] d);
    vec_t v;
    v          = mkIdle();
    v.req      = 1'b1;
    v.wr       = wr;
    v.aadr     = a;
    v.adbo     = d;
    v.exp_ack  = 1'b1;
    v.exp_we   = wr;
    v.exp_addr = a;
    return v;
  endfunction

  function automatic vec_t vdpVec(input logic we_n, input logic oe_n,
                                  input logic [14:0] a, input logic [7:0] d);
    vec_t v;
    v          = mkIdle();
    v.slot     = 1'b1;
    v.we_n     = we_n;
    v.oe_n     = oe_n;
    v.vadr     = a;
    v.vdbo     = d;
    v.exp_ack  = 1'b0;
    v.exp_we   = ~we_n;
    v.exp_addr = a;
    return v;
  endfunction

  // Drives one cycle: waits for the edge, updates the blocked-cycle model
  // from the cycle that just ended, then applies the new inputs and lets
  // them settle well before the next edge.
  task automatic applyStimulus(input vec_t v);
    @(posedge clk);
    if (prev.rst) exp_stat = 16'h0000;
    else if (prev.req && !prev.exp_ack && exp_stat != 16'hFFFF)
      exp_stat = exp_stat + 16'h0001;
    prev = v;
    #1;
    reset    = v.rst;
    vdp_slot = v.slot;
    vdp_we_n = v.we_n;
    vdp_oe_n = v.oe_n;
    vdp_adr  = v.vadr;
    vdp_dbo  = v.vdbo;
    aux_req  = v.req;
    aux_wr   = v.wr;
    aux_adr  = v.aadr;
    aux_dbo  = v.adbo;
    #2;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    check_cnt++;
    if (act === exp) pass_cnt++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic checkComb(input string name, input vec_t v);
    checkOutput({name, ".ack"},  32'(aux_ack),  32'(v.exp_ack));
    checkOutput({name, ".we"},   32'(ram_we),   32'(v.exp_we));
    checkOutput({name, ".addr"}, 32'(ram_addr), 32'(v.exp_addr));
  endtask

  initial begin
    vec_t        v;
    logic [14:0] rd_adr [6];
    logic [7:0]  rd_dat [6];

    pass_cnt  = 0;
    check_cnt = 0;
    exp_stat  = 16'h0000;

    // Grant-decoding table.
    tbl[0] = '{1'b0, 1'b0, 1'b1, 1'b1, 15'h0ABC, 8'h00,
               1'b0, 1'b0, 15'h0000, 8'h00, 1'b0, 1'b0, 15'h0ABC};
    tbl[1] = '{1'b0, 1'b1, 1'b1, 1'b0, 15'h0011, 8'h00,
               1'b0, 1'b0, 15'h0000, 8'h00, 1'b0, 1'b0, 15'h0011};
    tbl[2] = '{1'b0, 1'b1, 1'b0, 1'b1, 15'h0012, 8'h99,
               1'b1, 1'b1, 15'h0300, 8'h01, 1'b0, 1'b1, 15'h0012};
    tbl[3] = '{1'b0, 1'b1, 1'b0, 1'b0, 15'h0013, 8'h98,
               1'b1, 1'b1, 15'h0301, 8'h02, 1'b1, 1'b1, 15'h0301};
    tbl[4] = '{1'b0, 1'b1, 1'b0, 1'b0, 15'h0013, 8'h98,
               1'b1, 1'b0, 15'h0302, 8'h00, 1'b1, 1'b0, 15'h0302};
    tbl[5] = '{1'b0, 1'b1, 1'b1, 1'b1, 15'h0014, 8'h00,
               1'b1, 1'b0, 15'h0303, 8'h00, 1'b1, 1'b0, 15'h0303};
    tbl[6] = '{1'b0, 1'b0, 1'b0, 1'b1, 15'h0015, 8'h97,
               1'b1, 1'b1, 15'h0304, 8'h03, 1'b1, 1'b1, 15'h0304};
    tbl[7] = '{1'b0, 1'b0, 1'b1, 1'b1, 15'h0016, 8'h00,
               1'b0, 1'b1, 15'h0305, 8'h04, 1'b0, 1'b0, 15'h0016};

    rd_adr = '{15'h0020, 15'h0100, 15'h0101, 15'h0102, 15'h0103, 15'h0104};
    rd_dat = '{8'h77, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55};

    prev     = mkIdle();
    prev.rst = 1'b1;
    reset    = 1'b1;
    vdp_slot = 1'b0;
    vdp_we_n = 1'b1;
    vdp_oe_n = 1'b1;
    vdp_adr  = '0;
    vdp_dbo  = '0;
    aux_req  = 1'b1;
    aux_wr   = 1'b1;
    aux_adr  = 15'h0042;
    aux_dbo  = 8'hEE;

    // Reset held for three cycles with a pending aux write.
    v = auxVec(1'b1, 15'h0042, 8'hEE);
    v.rst     = 1'b1;
    v.exp_ack = 1'b0;
    v.exp_we  = 1'b0;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(v);
      checkOutput("rst.ack", 32'(aux_ack), 32'd0);
      checkOutput("rst.we",  32'(ram_we),  32'd0);
    end
    checkOutput("rst.vdp_dbi", 32'(vdp_dbi),      32'h00);
    checkOutput("rst.stat",    32'(stat_blocked), 32'h0000);
    checkOutput("rst.rvalid",  32'(aux_rvalid),   32'd0);

    // Aux write then aux read of the same address.
    v = auxVec(1'b1, 15'h1234, 8'hA5);
    applyStimulus(v);
    checkComb("wr1234", v);
    v = auxVec(1'b0, 15'h1234, 8'h00);
    applyStimulus(v);
    checkComb("rd1234", v);
    applyStimulus(mkIdle());
    checkOutput("rd1234.rvalid_t1", 32'(aux_rvalid), 32'd0);
    applyStimulus(mkIdle());
    checkOutput("rd1234.rvalid_t2", 32'(aux_rvalid), 32'd1);
    checkOutput("rd1234.rdata",     32'(aux_rdata),  32'hA5);
    applyStimulus(mkIdle());
    checkOutput("rd1234.rvalid_t3", 32'(aux_rvalid), 32'd0);

    // Table-driven grant checks.
    for (int i = 0; i < 8; i++) begin
      applyStimulus(tbl[i]);
      checkComb($sformatf("tbl%0d", i), tbl[i]);
    end

    // Preload through the aux port; also drains the table's aux reads.
    applyStimulus(auxVec(1'b1, 15'h0010, 8'h3C));
    for (int i = 0; i < 6; i++) applyStimulus(auxVec(1'b1, rd_adr[i], rd_dat[i]));
    applyStimulus(mkIdle());
    applyStimulus(mkIdle());
    checkOutput("pre.stat", 32'(stat_blocked), 32'(exp_stat));

    // VDP read in its slot while aux waits, then a run of aux reads.
    v = vdpVec(1'b1, 1'b0, 15'h0010, 8'h00);
    v.req  = 1'b1;
    v.wr   = 1'b0;
    v.aadr = 15'h0020;
    applyStimulus(v);
    checkComb("slotrd", v);
    for (int i = 0; i < 8; i++) begin
      if (i < 6) v = auxVec(1'b0, rd_adr[i], 8'h00);
      else       v = mkIdle();
      applyStimulus(v);
      if (i < 6) checkComb($sformatf("auxrd%0d", i), v);
      checkOutput($sformatf("hold%0d.vdp_dbi", i), 32'(vdp_dbi), 32'h3C);
      if (i == 0) checkOutput("slotrd.stat", 32'(stat_blocked), 32'(exp_stat));
      if (i >= 2) begin
        checkOutput($sformatf("auxrd%0d.rvalid", i - 2), 32'(aux_rvalid), 32'd1);
        checkOutput($sformatf("auxrd%0d.rdata", i - 2), 32'(aux_rdata),
                    32'(rd_dat[i-2]));
      end
    end

    // VDP write at the top address, aux reads it back the next cycle.
    v = vdpVec(1'b0, 1'b1, 15'h7FFF, 8'h5A);
    applyStimulus(v);
    checkComb("vdpwr7fff", v);
    v = auxVec(1'b0, 15'h7FFF, 8'h00);
    applyStimulus(v);
    checkComb("auxrd7fff", v);
    applyStimulus(mkIdle());
    applyStimulus(mkIdle());
    checkOutput("auxrd7fff.rvalid",  32'(aux_rvalid), 32'd1);
    checkOutput("auxrd7fff.rdata",   32'(aux_rdata),  32'h5A);
    checkOutput("vdpwr7fff.vdp_dbi", 32'(vdp_dbi),    32'h3C);

    // Reset arriving one cycle after an aux read ack.
    v = auxVec(1'b0, 15'h0100, 8'h00);
    applyStimulus(v);
    checkComb("rstrd", v);
    v     = mkIdle();
    v.rst = 1'b1;
    applyStimulus(v);
    checkOutput("rstrd.ack", 32'(aux_ack), 32'd0);
    checkOutput("rstrd.we",  32'(ram_we),  32'd0);
    applyStimulus(mkIdle());
    checkOutput("rstrd.rvalid_t2", 32'(aux_rvalid), 32'd0);
    applyStimulus(mkIdle());
    checkOutput("rstrd.rvalid_t3", 32'(aux_rvalid), 32'd0);
    checkOutput("rstrd.vdp_dbi",   32'(vdp_dbi),    32'h00);
    checkOutput("rstrd.stat",      32'(stat_blocked), 32'h0000);

    // Long block to drive the statistic into saturation.
    v = vdpVec(1'b1, 1'b0, 15'h0010, 8'h00);
    v.req  = 1'b1;
    v.aadr = 15'h0042;
    for (int i = 0; i < 65535; i++) applyStimulus(v);
    checkOutput("sat.fffe", 32'(stat_blocked), 32'hFFFE);
    applyStimulus(v);
    checkOutput("sat.ffff", 32'(stat_blocked), 32'hFFFF);
    for (int i = 0; i < 3; i++) applyStimulus(v);
    checkOutput("sat.hold", 32'(stat_blocked), 32'hFFFF);
    checkOutput("sat.model", 32'(stat_blocked), 32'(exp_stat));

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
